mul_share_sched: RTL and testbench

//  Shares one multi_pipe_8bit multiplier (N-cycle fixed latency, no stall) between NREQ requesters.

---
 rtl/mul_share_sched_if.sv | 31 +++
 rtl/mul_share_sched.sv | 187 ++++++++++++++++++
 tb/tb_mul_share_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_sched_if.sv
// ---------------------------------------------------------------------------
// mul_share_sched_if
// Requester-side bus of the shared multiplier scheduler.
//   req_valid  : per-requester operand pair valid
//   req_a/b    : packed operands, requester i at [i*W +: W]
//   req_ready  : one-hot grant back to the requesters
//   resp_valid : one-hot single-cycle result strobe to the owning requester
//   resp_data  : product, meaningful only alongside resp_valid
// master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface mul_share_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [2*W-1:0]    resp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mul_share_sched.sv
// ---------------------------------------------------------------------------
// mul_share_sched
// Shares one fixed-latency, non-stalling pipelined multiplier among NREQ
// requesters. A round-robin arbiter accepts at most one operand pair per
// cycle, a registered issue stage drives the multiplier, and a tag FIFO
// remembers which requester owns each in-flight product so the result can
// be steered back when the multiplier strobes it out. A flush input drains
// all in-flight work and reports completion with a one-cycle pulse.
//
// Ports
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req_bus     : requester bus (valid/operands in, grant/response out)
//   mul_en_in   : registered issue strobe to the multiplier
//   mul_a/mul_b : registered operands to the multiplier
//   mul_en_out  : result strobe from the multiplier
//   mul_out     : product from the multiplier
//   flush       : level request to stop granting and drain
//   flush_done  : one-cycle pulse once the drain has completed
//   busy        : tag FIFO non-empty or not in the RUN state
//   err_orphan  : sticky, a result strobe arrived with no owner recorded
// ---------------------------------------------------------------------------
module mul_share_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MAX_OUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_sched_if.slave    req_bus,
  output logic                mul_en_in,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic                mul_en_out,
  input  logic [2*W-1:0]      mul_out,
  input  logic                flush,
  output logic                flush_done,
  output logic                busy,
  output logic                err_orphan
);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTRW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW   = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, grant_id, cand, iss_id, head_id;
  logic            grant_found, grant_ok, transfer;
  logic [W-1:0]    sel_a, sel_b;
  logic [IDW-1:0]  tag_mem [MAX_OUT];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop, orphan;

  // Round-robin search: scan requesters starting at rr_ptr and take the
  // first one that is valid.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!grant_found && req_bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // A grant is only offered while running, not being asked to flush, and
  // with room for one more op counting both the FIFO and the op sitting in
  // the issue register that has not been pushed yet.
  assign grant_ok = !rst && (state == RUN) && !flush &&
                    ((int'(count) + int'(mul_en_in)) < MAX_OUT);
  assign transfer = grant_ok && grant_found;

  always_comb begin
    req_bus.req_ready = '0;
    if (transfer) req_bus.req_ready[grant_id] = 1'b1;
  end

  // Pick the winner's operands out of the packed request vectors.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_bus.req_a[i*W +: W];
        sel_b = req_bus.req_b[i*W +: W];
      end
    end
  end

  // Issue register: one cycle after a transfer the multiplier sees the
  // operands with mul_en_in; operands are forced to zero otherwise. The
  // round-robin pointer advances past the winner only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_en_in <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      iss_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      mul_en_in <= transfer;
      mul_a     <= transfer ? sel_a : '0;
      mul_b     <= transfer ? sel_b : '0;
      if (transfer) begin
        iss_id <= grant_id;
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // The owner tag is pushed while its op is on the multiplier input; a
  // result strobe pops the oldest tag. A strobe with nothing recorded is an
  // orphan and leaves the FIFO untouched.
  assign push    = mul_en_in;
  assign pop     = mul_en_out && (count != '0);
  assign orphan  = mul_en_out && (count == '0);
  assign head_id = tag_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // Tag storage needs no reset; only the pointers and count define what is
  // live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= iss_id;
  end

  // FIFO pointers, occupancy and the sticky orphan flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTRW'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTRW'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
      if (orphan) err_orphan <= 1'b1;
    end
  end

  // Results go straight from the multiplier to the owning requester in the
  // same cycle; the data bus is zeroed whenever there is no strobe.
  always_comb begin
    req_bus.resp_valid = '0;
    req_bus.resp_data  = '0;
    if (pop) begin
      req_bus.resp_valid[head_id] = 1'b1;
      req_bus.resp_data           = mul_out;
    end
  end

  // Flush state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Flush sequencing. DRAIN finishes on the cycle the FIFO is about to go
  // empty, so flush_done lands one cycle after the last response. HOLD waits
  // for flush to drop so one request yields exactly one pulse.
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if ((count_nxt == '0) && !mul_en_in) state_nxt = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = HOLD;
      end
      HOLD:    if (!flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign busy = (count != '0) || (state != RUN);

endmodule

// File: tb/tb_mul_share_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_share_sched
// Directed bench for mul_share_sched with a behavioural pipelined multiplier
// whose latency is selectable. A table of single-op vectors covers routing
// and operand extremes; hand-written sequences cover round-robin order,
// FIFO full, flush/drain, orphan strobes and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_mul_share_sched;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int MAX_OUT = 8;

  // Per-requester operands used by the multi-requester sequences:
  // requester i gets a=i+1, b=i+3.
  localparam logic [31:0] RA = 32'h04030201;
  localparam logic [31:0] RB = 32'h06050403;

  typedef struct {
    logic [1:0]  rid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [3:0]  mask;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
  } resp_t;

  logic        clk, rst, flush_r, flush_done, busy, err_orphan;
  logic        mul_en_in, mul_en_out, orphan_inj;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_out;
  logic [3:0]  lat_tap;
  logic [15:0] en_pipe;
  logic [15:0] prod_pipe [16];
  logic [15:0] rr_prod [4];
  vec_t        vecs [5];
  resp_t       exp_q [$];
  resp_t       mon_e;
  int          total, bad;

  mul_share_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  mul_share_sched #(.NREQ(NREQ), .W(W), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_bus    (bus),
    .mul_en_in  (mul_en_in),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en_out (mul_en_out),
    .mul_out    (mul_out),
    .flush      (flush_r),
    .flush_done (flush_done),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural multiplier: a shift chain of strobes and products, tapped at
  // lat_tap so the result appears lat_tap+1 cycles after mul_en_in. It shares
  // the scheduler's reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
      for (int i = 0; i < 16; i++) prod_pipe[i] <= '0;
    end else begin
      en_pipe      <= {en_pipe[14:0], mul_en_in};
      prod_pipe[0] <= {8'd0, mul_a} * {8'd0, mul_b};
      for (int i = 1; i < 16; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  assign mul_en_out = en_pipe[lat_tap] | orphan_inj;
  assign mul_out    = prod_pipe[lat_tap];

  // Hard stop in case something wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle before the
  // caller samples.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    flush_r       = fl;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'h0, '0, '0, 1'b0);
  endtask

  // Check the grant of this cycle against the expected winner (-1 = none)
  // and queue the response the RA/RB operands should produce.
  task automatic expectGrant(input string name, input int id);
    logic [3:0] m;
    m = (id < 0) ? 4'h0 : 4'(1 << id);
    checkOutput(name, 32'(bus.req_ready), 32'(m));
    if (id >= 0) exp_q.push_back('{m, rr_prod[id]});
  endtask

  task automatic runVector(input vec_t v);
    logic [31:0] av, bv;
    int k;
    av = '0;
    bv = '0;
    av[int'(v.rid)*8 +: 8] = v.a;
    bv[int'(v.rid)*8 +: 8] = v.b;
    applyStimulus(v.mask, av, bv, 1'b0);
    checkOutput("single_ready", 32'(bus.req_ready), 32'(v.mask));
    exp_q.push_back('{v.mask, v.prod});
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("single_issue", {15'd0, mul_en_in, mul_a, mul_b},
                {15'd0, 1'b1, v.a, v.b});
    k = 0;
    for (int n = 1; n <= 20 && k == 0; n++) begin
      applyStimulus(4'h0, '0, '0, 1'b0);
      if (n == 1) checkOutput("issue_clear", {15'd0, mul_en_in, mul_a, mul_b}, 32'd0);
      if (bus.resp_valid != '0) k = n;
    end
    checkOutput("single_latency", 32'(k), 32'd4);
    checkOutput("single_mask", 32'(bus.resp_valid), 32'(v.mask));
    checkOutput("single_data", 32'(bus.resp_data), 32'(v.prod));
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("single_after", {12'd0, bus.resp_valid, bus.resp_data}, 32'd0);
  endtask

  // Response scoreboard: every strobe must match the oldest expected
  // response, and a strobe with nothing expected is an error.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("resp_mask", 32'(bus.resp_valid), 32'(mon_e.mask));
        checkOutput("resp_data", 32'(bus.resp_data), 32'(mon_e.data));
      end
    end
  end

  // Main test sequence.
  initial begin
    int id;
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    flush_r       = 1'b0;
    orphan_inj    = 1'b0;
    lat_tap       = 4'd3;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    rr_prod[0] = 16'd3;
    rr_prod[1] = 16'd8;
    rr_prod[2] = 16'd15;
    rr_prod[3] = 16'd24;

    vecs[0] = '{2'd2, 8'd13,  8'd11,  16'd143,   4'b0100};
    vecs[1] = '{2'd0, 8'hFF,  8'hFF,  16'hFE01,  4'b0001};
    vecs[2] = '{2'd3, 8'h00,  8'hFF,  16'h0000,  4'b1000};
    vecs[3] = '{2'd1, 8'h80,  8'h02,  16'h0100,  4'b0010};
    vecs[4] = '{2'd2, 8'h0F,  8'h10,  16'h00F0,  4'b0100};

    // Reset with requests pending: every output must stay low.
    #2;
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = RA;
    bus.req_b     = RB;
    @(negedge clk);
    #1;
    checkOutput("rst_ready",  32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp",   {12'd0, bus.resp_valid, bus.resp_data}, 32'd0);
    checkOutput("rst_issue",  {15'd0, mul_en_in, mul_a, mul_b}, 32'd0);
    checkOutput("rst_status", {29'd0, flush_done, busy, err_orphan}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = '0;

    // Round robin with everyone requesting.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'hF, RA, RB, 1'b0);
      expectGrant("rr_grant", c % 4);
    end
    idle(12);
    checkOutput("rr_drained", 32'(exp_q.size()), 32'd0);

    // Table of single operations.
    foreach (vecs[i]) runVector(vecs[i]);

    // Flush with three ops in flight.
    for (int c = 0; c < 12; c++) begin
      case (c)
        0:       applyStimulus(4'b0010, RA, RB, 1'b0);
        1:       applyStimulus(4'b0100, RA, RB, 1'b0);
        2:       applyStimulus(4'b1000, RA, RB, 1'b0);
        default: applyStimulus(4'hF, RA, RB, (c >= 3 && c <= 9));
      endcase
      id = (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 3 : (c == 11) ? 0 : -1;
      expectGrant("flush_grant", id);
      checkOutput("flush_done_pulse", 32'(flush_done), 32'(c == 8));
      if (c >= 3 && c <= 10) checkOutput("flush_busy", 32'(busy), 32'd1);
    end
    idle(10);
    checkOutput("flush_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);

    // Flush with nothing outstanding, released while draining.
    applyStimulus(4'h0, '0, '0, 1'b1);
    checkOutput("eflush_f0", 32'(flush_done), 32'd0);
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("eflush_f1", {30'd0, flush_done, busy}, 32'd1);
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("eflush_f2", 32'(flush_done), 32'd1);
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("eflush_f3", {30'd0, flush_done, busy}, 32'd1);
    applyStimulus(4'hF, RA, RB, 1'b0);
    expectGrant("eflush_resume", 1);
    idle(10);

    // FIFO full: slow multiplier, continuous requests from a fresh pointer.
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    lat_tap = 4'd11;
    for (int c = 0; c < 15; c++) begin
      applyStimulus(4'hF, RA, RB, 1'b0);
      id = (c < 8) ? (c % 4) : (c == 14) ? 0 : -1;
      expectGrant("full_grant", id);
    end
    idle(20);
    checkOutput("full_drained", 32'(exp_q.size()), 32'd0);
    lat_tap = 4'd3;

    // Orphan result strobe.
    idle(2);
    checkOutput("orphan_clear", 32'(err_orphan), 32'd0);
    @(negedge clk);
    orphan_inj = 1'b1;
    #1;
    checkOutput("orphan_no_resp", {12'd0, bus.resp_valid, bus.resp_data}, 32'd0);
    @(negedge clk);
    orphan_inj = 1'b0;
    #1;
    checkOutput("orphan_flag", 32'(err_orphan), 32'd1);
    idle(3);
    checkOutput("orphan_sticky", 32'(err_orphan), 32'd1);

    // Reset in the middle of a burst.
    applyStimulus(4'b0001, RA, RB, 1'b0);
    expectGrant("burst_grant", 0);
    applyStimulus(4'b0010, RA, RB, 1'b0);
    expectGrant("burst_grant", 1);
    applyStimulus(4'b0100, RA, RB, 1'b0);
    expectGrant("burst_grant", 2);
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    exp_q.delete();
    #1;
    checkOutput("midrst_ready",  32'(bus.req_ready), 32'd0);
    checkOutput("midrst_resp",   {12'd0, bus.resp_valid, bus.resp_data}, 32'd0);
    checkOutput("midrst_issue",  {15'd0, mul_en_in, mul_a, mul_b}, 32'd0);
    checkOutput("midrst_status", {29'd0, flush_done, busy, err_orphan}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expectGrant("midrst_ptr0", 0);
    applyStimulus(4'hF, RA, RB, 1'b0);
    expectGrant("midrst_ptr1", 1);
    idle(12);
    checkOutput("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
